genius_ctrl: RTL and testbench

Control FSM for the Genius memory game. It sits directly upstream of the game datapath. It consumes the datapath status flags (`end_FPGA`, `end_User`, `end_time`, `win`, `match`) and the player's confirm key. It produces the datapath control strobes (`R1`, `R2`, `E1`–`E4`, `SEL`) that sequence setup, FPGA playback, user entry, checking and the result display.

---
 rtl/genius_pkg.sv | 48 ++++
 rtl/genius_ctrl_key_pulse.sv | 38 +++
 rtl/genius_ctrl.sv | 90 +++++++++
 tb/tb_genius_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game controller: state encodings,
// the control-strobe bundle and the per-state strobe decode.
package genius_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_SETUP  = 4'd1,
        ST_PREP   = 4'd2,
        ST_SEQ    = 4'd3,
        ST_PLAY   = 4'd4,
        ST_CHECK  = 4'd5,
        ST_NEXT   = 4'd6,
        ST_EVAL   = 4'd7,
        ST_RESULT = 4'd8
    } state_e;

    typedef struct packed {
        logic r1;
        logic r2;
        logic e1;
        logic e2;
        logic e3;
        logic e4;
        logic sel;
    } ctrl_t;

    // Illegal codes decode like INIT so the datapath is held in reset until recovery.
    function automatic ctrl_t decode_ctrl(input state_e st);
        ctrl_t c;
        c = '0;
        case (st)
            ST_INIT:   begin c.r1 = 1'b1; c.r2 = 1'b1; c.sel = 1'b1; end
            ST_SETUP:  begin c.e1 = 1'b1; c.sel = 1'b1; end
            ST_PREP:   begin c.r2 = 1'b1; c.sel = 1'b1; end
            ST_SEQ:    begin c.e3 = 1'b1; c.sel = 1'b1; end
            ST_PLAY:   begin c.e2 = 1'b1; c.sel = 1'b1; end
            ST_CHECK:  begin c.sel = 1'b1; end
            ST_NEXT:   begin c.e4 = 1'b1; c.sel = 1'b1; end
            ST_EVAL:   begin c.sel = 1'b1; end
            ST_RESULT: begin c.sel = 1'b0; end
            default:   begin c.r1 = 1'b1; c.r2 = 1'b1; c.sel = 1'b1; end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/genius_ctrl_key_pulse.sv
// Confirm-key conditioning: multi-flop synchronizer plus a one-cycle
// falling-edge pulse on the synchronized key.
module key_pulse #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key_n,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] valid_q;
    logic                   hist_q;
    logic                   armed_q;
    logic                   key_s;

    assign key_s = sync_q[SYNC_STAGES-1];

    // valid_q marks when key_s holds a real sample rather than a reset value;
    // armed_q requires one real released sample, so a key held through reset never pulses.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_q  <= '1;
            valid_q <= '0;
            hist_q  <= 1'b1;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], key_n};
            valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            hist_q  <= key_s;
            armed_q <= armed_q | (valid_q[SYNC_STAGES-1] & key_s);
        end
    end

    assign pulse = armed_q & hist_q & ~key_s;

endmodule

// File: rtl/genius_ctrl.sv
// Control FSM for the Genius memory game: sequences setup, FPGA playback,
// user entry, checking and result display through Moore-decoded strobes.
module genius_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int STATE_W     = 4
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               enter_n,
    input  logic               end_FPGA,
    input  logic               end_User,
    input  logic               end_time,
    input  logic               win,
    input  logic               match,
    output logic               R1,
    output logic               R2,
    output logic               E1,
    output logic               E2,
    output logic               E3,
    output logic               E4,
    output logic               SEL,
    output logic [STATE_W-1:0] state_o
);

    import genius_pkg::*;

    state_e state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;
    logic   press_s;

    key_pulse #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_key_pulse (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .key_n    (enter_n),
        .pulse    (press_s)
    );

    // Next-state logic; end_User wins over end_time when both arrive together.
    always_comb begin
        state_d = ST_INIT;
        case (state_q)
            ST_INIT:   state_d = ST_SETUP;
            ST_SETUP:  if (press_s) state_d = ST_PREP; else state_d = ST_SETUP;
            ST_PREP:   state_d = ST_SEQ;
            ST_SEQ:    if (end_FPGA) state_d = ST_PLAY; else state_d = ST_SEQ;
            ST_PLAY: begin
                if (end_User) begin
                    state_d = ST_CHECK;
                end else if (end_time) begin
                    state_d = ST_RESULT;
                end else begin
                    state_d = ST_PLAY;
                end
            end
            ST_CHECK:  if (match) state_d = ST_NEXT; else state_d = ST_RESULT;
            ST_NEXT:   state_d = ST_EVAL;
            ST_EVAL:   if (win) state_d = ST_RESULT; else state_d = ST_PREP;
            ST_RESULT: if (press_s) state_d = ST_INIT; else state_d = ST_RESULT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Strobes are decoded from the next state so the registered outputs track state_q.
    always_comb begin
        ctrl_d = decode_ctrl(state_d);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_INIT;
            ctrl_q  <= decode_ctrl(ST_INIT);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign R1      = ctrl_q.r1;
    assign R2      = ctrl_q.r2;
    assign E1      = ctrl_q.e1;
    assign E2      = ctrl_q.e2;
    assign E3      = ctrl_q.e3;
    assign E4      = ctrl_q.e4;
    assign SEL     = ctrl_q.sel;
    assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_genius_ctrl.sv
// Directed bench for genius_ctrl: a per-cycle vector table plus hand-written
// sequences for key hold, key held through reset and press latency.
module tb_genius_ctrl;

    logic       clk = 1'b0;
    logic       reset, enter_n, end_FPGA, end_User, end_time, win, match;
    logic       R1, R2, E1, E2, E3, E4, SEL;
    logic [3:0] state_o;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] S_INIT = 4'd0, S_SETUP = 4'd1, S_PREP = 4'd2, S_SEQ = 4'd3,
                           S_PLAY = 4'd4, S_CHECK = 4'd5, S_NEXT = 4'd6, S_EVAL = 4'd7,
                           S_RESULT = 4'd8;

    typedef struct {
        logic       rst, en_n, fpga, user, tim, w, m;
        logic [3:0] st;
        logic [6:0] outs;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    genius_ctrl dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .enter_n  (enter_n),
        .end_FPGA (end_FPGA),
        .end_User (end_User),
        .end_time (end_time),
        .win      (win),
        .match    (match),
        .R1       (R1),
        .R2       (R2),
        .E1       (E1),
        .E2       (E2),
        .E3       (E3),
        .E4       (E4),
        .SEL      (SEL),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    // Expected {R1,R2,E1,E2,E3,E4,SEL} per state, written out from the state list.
    function automatic logic [6:0] exp_outs(input logic [3:0] st);
        case (st)
            S_INIT:   return 7'b1100001;
            S_SETUP:  return 7'b0010001;
            S_PREP:   return 7'b0100001;
            S_SEQ:    return 7'b0000101;
            S_PLAY:   return 7'b0001001;
            S_CHECK:  return 7'b0000001;
            S_NEXT:   return 7'b0000011;
            S_EVAL:   return 7'b0000001;
            S_RESULT: return 7'b0000000;
            default:  return 7'b1100001;
        endcase
    endfunction

    task automatic add(input logic rst, en_n, fpga, user, tim, w, m, input logic [3:0] st);
        vecs[nv] = '{rst: rst, en_n: en_n, fpga: fpga, user: user, tim: tim, w: w, m: m,
                     st: st, outs: exp_outs(st)};
        nv++;
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, en_n, fpga, user, tim, w, m);
        reset = rst; enter_n = en_n; end_FPGA = fpga; end_User = user;
        end_time = tim; win = w; match = m;
    endtask

    int prep_cnt;
    int bad_cnt;

    initial begin
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        //  rst   en_n  fpga  user  tim   win   match  expected state
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, S_SEQ);    // flags ignored in SEQ
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);    // press during SEQ
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_CHECK);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_NEXT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_EVAL);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, S_CHECK);  // both flags: end_User wins
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT); // mismatch
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_RESULT); // timeout
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, S_CHECK);  // win ignored in PLAY
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, S_NEXT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_EVAL);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_RESULT); // final round won
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_RESULT);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_INIT);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PREP);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SEQ);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_PLAY);
        add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, S_INIT);   // reset mid-PLAY
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, S_SETUP);

        for (int i = 0; i < nv; i++) begin
            drive(vecs[i].rst, vecs[i].en_n, vecs[i].fpga, vecs[i].user,
                  vecs[i].tim, vecs[i].w, vecs[i].m);
            tick();
            check($sformatf("vec%0d_state", i), {3'b000, state_o}, {3'b000, vecs[i].st});
            check($sformatf("vec%0d_outs", i), {R1, R2, E1, E2, E3, E4, SEL}, vecs[i].outs);
        end

        // Key held low for 100 cycles in SETUP: exactly one PREP entry.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check("hold_setup_state", {3'b000, state_o}, {3'b000, S_SETUP});
        prep_cnt = 0;
        enter_n  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (state_o == S_PREP) prep_cnt++;
        end
        check("hold_prep_count", 7'(prep_cnt), 7'd1);
        check("hold_end_state", {3'b000, state_o}, {3'b000, S_SEQ});
        enter_n = 1'b1;

        // Key held low through reset and afterwards: no press.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check("rsthold_init", {3'b000, state_o}, {3'b000, S_INIT});
        reset   = 1'b0;
        bad_cnt = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (state_o != S_SETUP) bad_cnt++;
        end
        check("rsthold_no_press", 7'(bad_cnt), 7'd0);
        enter_n = 1'b1;
        repeat (4) tick();
        check("rsthold_release", {3'b000, state_o}, {3'b000, S_SETUP});

        // Press latency: low at edge k, still SETUP after k+1, PREP after k+2.
        enter_n = 1'b0;
        tick();
        tick();
        check("lat_k1", {3'b000, state_o}, {3'b000, S_SETUP});
        tick();
        check("lat_k2", {3'b000, state_o}, {3'b000, S_PREP});
        check("lat_r2", {6'b000000, R2}, 7'd1);
        enter_n = 1'b1;
        tick();
        check("lat_seq", {3'b000, state_o}, {3'b000, S_SEQ});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
